// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: tracks SCL edges inside an I2C frame and issues the one-cycle
// strobes that the slave controller uses (byte_received, ack_prep,
// check_ack, ack_done). It also provides the running data-bit count.
// Optional build macro I2C_BIT_TIMER_ERR_EN adds a proto_err output. That
// output pulses when a START or STOP cuts a data byte short.
module i2c_bit_timer #(
    parameter int unsigned BITS_PER_BYTE = 8   // legal range 2..15
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    output logic       byte_received,
    output logic       ack_prep,
    output logic       check_ack,
    output logic       ack_done,
    output logic [3:0] bit_count,
    output logic       busy
`ifdef I2C_BIT_TIMER_ERR_EN
    ,
    output logic       proto_err
`endif
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT_LOW,
        ST_ACK_HIGH,
        ST_ACK_LOW
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] bit_count_q, bit_count_d;
    logic       byte_received_q, byte_received_d;
    logic       ack_prep_q, ack_prep_d;
    logic       check_ack_q, check_ack_d;
    logic       ack_done_q, ack_done_d;
    logic       busy_q, busy_d;

    // A rise and a fall reported in the same cycle are a glitch, so both are dropped.
    logic rise_ok, fall_ok;
    assign rise_ok = rising_edge_found & ~falling_edge_found;
    assign fall_ok = falling_edge_found & ~rising_edge_found;

    // Next-state and strobe decode. Priority is STOP, then START, then SCL edges.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d         = state_q;
        bit_count_d     = bit_count_q;
        byte_received_d = 1'b0;
        ack_prep_d      = 1'b0;
        check_ack_d     = 1'b0;
        ack_done_d      = 1'b0;

        if (stop_found) begin
            state_d     = ST_IDLE;
            bit_count_d = 4'd0;
        end else if (start_found) begin
            state_d     = ST_DATA;
            bit_count_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_DATA: begin
                    if (rise_ok && bit_count_q < LAST_BIT) begin
                        bit_count_d = bit_count_q + 4'd1;
                        if (bit_count_q + 4'd1 == LAST_BIT) begin
                            byte_received_d = 1'b1;
                            state_d         = ST_WAIT_LOW;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (fall_ok) begin
                        ack_prep_d = 1'b1;
                        state_d    = ST_ACK_HIGH;
                    end
                end
                ST_ACK_HIGH: begin
                    if (rise_ok) begin
                        check_ack_d = 1'b1;
                        state_d     = ST_ACK_LOW;
                    end
                end
                ST_ACK_LOW: begin
                    if (fall_ok) begin
                        ack_done_d  = 1'b1;
                        bit_count_d = 4'd0;
                        state_d     = ST_DATA;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    bit_count_d = 4'd0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: reset is asynchronous so that every output drops the moment n_rst falls.
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            bit_count_q     <= 4'd0;
            byte_received_q <= 1'b0;
            ack_prep_q      <= 1'b0;
            check_ack_q     <= 1'b0;
            ack_done_q      <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so that all registers update together on the edge.
            state_q         <= state_d;
            bit_count_q     <= bit_count_d;
            byte_received_q <= byte_received_d;
            ack_prep_q      <= ack_prep_d;
            check_ack_q     <= check_ack_d;
            ack_done_q      <= ack_done_d;
            busy_q          <= busy_d;
        end
    end

    assign byte_received = byte_received_q;
    assign ack_prep      = ack_prep_q;
    assign check_ack     = check_ack_q;
    assign ack_done      = ack_done_q;
    assign bit_count     = bit_count_q;
    assign busy          = busy_q;

`ifdef I2C_BIT_TIMER_ERR_EN
    logic proto_err_q, proto_err_d;

    // A START or STOP that arrives while a data byte is only partly sampled aborts that frame.
    always_comb begin
        proto_err_d = (start_found | stop_found) && (state_q == ST_DATA) &&
                      (bit_count_q != 4'd0) && (bit_count_q < LAST_BIT);
    end

    // Register the abort pulse so that it lines up with the other strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) proto_err_q <= 1'b0;
        else        proto_err_q <= proto_err_d;
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Self-checking bench for i2c_bit_timer. A frame-progress reference model
// predicts every output on every cycle. Directed scenarios come first,
// followed by randomized START/STOP/edge traffic.
module tb_i2c_bit_timer;

    localparam int BPB = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_found, stop_found, rising_edge_found, falling_edge_found;
    logic       byte_received, ack_prep, check_ack, ack_done, busy;
    logic [3:0] bit_count;
`ifdef I2C_BIT_TIMER_ERR_EN
    logic       proto_err;
`endif

    i2c_bit_timer #(.BITS_PER_BYTE(BPB)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_found        (start_found),
        .stop_found         (stop_found),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .byte_received      (byte_received),
        .ack_prep           (ack_prep),
        .check_ack          (check_ack),
        .ack_done           (ack_done),
        .bit_count          (bit_count),
        .busy               (busy)
`ifdef I2C_BIT_TIMER_ERR_EN
        ,
        .proto_err          (proto_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model. progress is -1 when no frame is open. Values
    // 0..BPB count the data bits sampled so far; BPB means the byte is
    // complete and the model waits for SCL low. BPB+1 means the ACK
    // slot is open, and BPB+2 means the ACK has been sampled.
    int progress = -1;
    bit e_byte, e_prep, e_chk, e_done, e_err;

    // Observed strobe tallies, used for the whole-scenario counts.
    int cnt_byte, cnt_prep, cnt_chk, cnt_done, cnt_err;

    function automatic int exp_count();
        if (progress < 0)   return 0;
        if (progress > BPB) return BPB;
        return progress;
    endfunction

    task automatic model_update(input bit st, input bit sp, input bit r, input bit f);
        bit qr, qf, mid;
        qr = r && !f;
        qf = f && !r;
        {e_byte, e_prep, e_chk, e_done, e_err} = '0;
        mid = (progress > 0) && (progress < BPB);
        if (sp) begin
            e_err = mid;
            progress = -1;
        end else if (st) begin
            e_err = mid;
            progress = 0;
        end else if (progress < 0) begin
        end else if (progress < BPB) begin
            if (qr) begin
                progress++;
                e_byte = (progress == BPB);
            end
        end else if (progress == BPB) begin
            if (qf) begin e_prep = 1; progress++; end
        end else if (progress == BPB + 1) begin
            if (qr) begin e_chk = 1; progress++; end
        end else begin
            if (qf) begin e_done = 1; progress = 0; end
        end
    endtask

    task automatic compare_all();
        check("byte_received", byte_received, e_byte);
        check("ack_prep", ack_prep, e_prep);
        check("check_ack", check_ack, e_chk);
        check("ack_done", ack_done, e_done);
        check("bit_count", bit_count, exp_count());
        check("busy", busy, progress >= 0);
`ifdef I2C_BIT_TIMER_ERR_EN
        check("proto_err", proto_err, e_err);
`endif
    endtask

    // Drive one cycle of inputs, then compare the outputs 1 ns after the edge.
    task automatic step(input bit st, input bit sp, input bit r, input bit f);
        start_found        = st;
        stop_found         = sp;
        rising_edge_found  = r;
        falling_edge_found = f;
        @(posedge clk);
        model_update(st, sp, r, f);
        #1;
        compare_all();
        cnt_byte += int'(byte_received);
        cnt_prep += int'(ack_prep);
        cnt_chk  += int'(check_ack);
        cnt_done += int'(ack_done);
`ifdef I2C_BIT_TIMER_ERR_EN
        cnt_err  += int'(proto_err);
`endif
    endtask

    task automatic clear_tallies();
        {cnt_byte, cnt_prep, cnt_chk, cnt_done, cnt_err} = '0;
    endtask

    task automatic rise(); step(0, 0, 1, 0); endtask
    task automatic fall(); step(0, 0, 0, 1); endtask

    initial begin
        n_rst = 1'b0;
        {start_found, stop_found, rising_edge_found, falling_edge_found} = '0;
        clear_tallies();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk) n_rst = 1'b1;

        // Outside a frame, edges change nothing.
        rise(); fall(); step(0, 0, 0, 0);

        // Full byte with its ACK slot.
        clear_tallies();
        step(1, 0, 0, 0);
        for (int i = 0; i < BPB; i++) begin rise(); fall(); end
        rise(); fall();
        check("full_bc_after", bit_count, 0);
        check("full_busy_after", busy, 1);

        // A second byte directly after the first one.
        for (int i = 0; i < BPB; i++) begin fall(); rise(); end
        fall(); rise(); fall();
        check("b2b_byte_cnt", cnt_byte, 2);
        check("b2b_prep_cnt", cnt_prep, 2);
        check("b2b_chk_cnt", cnt_chk, 2);
        check("b2b_done_cnt", cnt_done, 2);

        // Repeated START after 3 bits, then a complete byte.
        clear_tallies();
        for (int i = 0; i < 3; i++) begin rise(); fall(); end
        step(1, 0, 1, 0);             // the start wins and the edge is discarded
        check("rs_bc", bit_count, 0);
`ifdef I2C_BIT_TIMER_ERR_EN
        check("rs_err_cnt", cnt_err, 1);
`endif
        for (int i = 0; i < BPB; i++) begin rise(); fall(); end
        check("rs_byte_cnt", cnt_byte, 1);

        // STOP in ACK_HIGH; check_ack must never fire.
        clear_tallies();
        step(0, 1, 1, 0);
        check("stop_ack_busy", busy, 0);
        check("stop_ack_chk", cnt_chk, 0);
        // A simultaneous START and STOP also ends in IDLE.
        step(1, 0, 0, 0); rise();
        step(1, 1, 0, 0);
        check("start_stop_busy", busy, 0);

        // Glitch at bit_count 2.
        step(1, 0, 0, 0); rise(); fall(); rise();
        clear_tallies();
        step(0, 0, 1, 1);
        check("glitch_bc", bit_count, 2);
        check("glitch_strobes", cnt_byte + cnt_prep + cnt_chk + cnt_done, 0);

        // Asynchronous reset in the middle of a frame at bit_count 5.
        rise(); rise(); rise();
        check("pre_reset_bc", bit_count, 5);
        #2 n_rst = 1'b0;
        #1;
        progress = -1;
        {e_byte, e_prep, e_chk, e_done, e_err} = '0;
        compare_all();
        @(negedge clk) n_rst = 1'b1;
        rise(); fall(); rise();
        check("post_reset_bc", bit_count, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r, e;
            bit st, sp;
            r  = int'($urandom_range(0, 99));
            st = (r < 3);
            sp = (r >= 3 && r < 5);
            e  = int'($urandom_range(0, 9));
            step(st, sp, e < 4 || e == 8, (e >= 4 && e < 8) || e == 8);
        end

        {start_found, stop_found, rising_edge_found, falling_edge_found} = '0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
